// File: rtl/coin_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coin_pkg
//  Description : Shared types and constants for the coin acceptor: coin code
//                enum, coin values, value decode function and FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_1  = 2'b00,
    COIN_5  = 2'b01,
    COIN_10 = 2'b10,
    COIN_50 = 2'b11
  } coin_code_t;

  localparam logic [7:0] COIN_VAL_1  = 8'd1;
  localparam logic [7:0] COIN_VAL_5  = 8'd5;
  localparam logic [7:0] COIN_VAL_10 = 8'd10;
  localparam logic [7:0] COIN_VAL_50 = 8'd50;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } acc_state_t;

  function automatic logic [7:0] coin_value(input coin_code_t code);
    logic [7:0] val;
    val = COIN_VAL_1;
    case (code)
      COIN_1:  val = COIN_VAL_1;
      COIN_5:  val = COIN_VAL_5;
      COIN_10: val = COIN_VAL_10;
      COIN_50: val = COIN_VAL_50;
      default: val = COIN_VAL_1;
    endcase
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coin_acceptor_if.sv
`default_nettype none
// ============================================================================
//  Module      : coin_acceptor_if
//  Description : Coin-side handshake plus controller-side money/credit bus.
//                master : coin source / controller side (drives coins, enables)
//                slave  : coin_acceptor
//  Signals     : coin_valid, coin_code[1:0], coin_ready, accept_en,
//                session_clear, input_money[7:0], coin_reject,
//                reject_value[7:0], credit[7:0], fifo_count,
//                audit_counts[63:0] (only with COIN_AUDIT_EN)
//  Macro       : COIN_AUDIT_EN
//  Revision    : 1.0  initial release
// ============================================================================
interface coin_acceptor_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             coin_valid;
  logic [1:0]       coin_code;
  logic             coin_ready;
  logic             accept_en;
  logic             session_clear;
  logic [7:0]       input_money;
  logic             coin_reject;
  logic [7:0]       reject_value;
  logic [7:0]       credit;
  logic [CNT_W-1:0] fifo_count;
`ifdef COIN_AUDIT_EN
  logic [63:0]      audit_counts;

  modport master (
    output coin_valid, coin_code, accept_en, session_clear,
    input  coin_ready, input_money, coin_reject, reject_value, credit,
           fifo_count, audit_counts
  );
  modport slave (
    input  coin_valid, coin_code, accept_en, session_clear,
    output coin_ready, input_money, coin_reject, reject_value, credit,
           fifo_count, audit_counts
  );
`else
  modport master (
    output coin_valid, coin_code, accept_en, session_clear,
    input  coin_ready, input_money, coin_reject, reject_value, credit,
           fifo_count
  );
  modport slave (
    input  coin_valid, coin_code, accept_en, session_clear,
    output coin_ready, input_money, coin_reject, reject_value, credit,
           fifo_count
  );
`endif

endinterface
`default_nettype wire

// File: rtl/coin_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : coin_fifo
//  Description : DEPTH x WIDTH synchronous FIFO, first-word fall-through read
//                port (rdata_o shows the head entry whenever not empty).
//  Ports       : clk, reset (async, active-high), push_i, pop_i, wdata_i,
//                rdata_o, count_o, full_o, empty_o
//  Revision    : 1.0  initial release
// ============================================================================
module coin_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  input  wire logic                         push_i,
  input  wire logic                         pop_i,
  input  wire logic [WIDTH-1:0]             wdata_i,
  output logic      [WIDTH-1:0]             rdata_o,
  output logic      [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                              full_o,
  output logic                              empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en_w;
  logic             rd_en_w;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_en_w = push_i && !full_o;
  assign rd_en_w = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (wr_en_w) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_w) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en_w) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en_w, rd_en_w})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
//  Module      : coin_acceptor
//  Description : Buffers coded coins from a valid/ready handshake, enforces a
//                session credit ceiling, and replays each queued coin to the
//                vending controller as a one-cycle input_money pulse followed
//                by at least two zero cycles (IDLE -> PRESENT -> GAP).
//  Ports       : clk, reset (async, active-high), bus (coin_acceptor_if.slave)
//  Macro       : COIN_AUDIT_EN - adds bus.audit_counts, four 16-bit saturating
//                per-code counters of accepted coins.
//  Revision    : 1.0  initial release
// ============================================================================
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] MAX_CREDIT = 8'd200
) (
  input wire logic       clk,
  input wire logic       reset,
  coin_acceptor_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [7:0]       coin_val_w;
  logic [8:0]       credit_sum_w;
  logic             over_w;
  logic             push_w;
  logic             enq_w;
  logic             rej_w;
  logic             pop_w;
  logic [7:0]       head_w;
  logic [CNT_W-1:0] count_w;
  logic             full_w;
  logic             empty_w;

  acc_state_t       state_q;
  logic [7:0]       money_q;
  logic [7:0]       credit_q,     credit_d;
  logic [7:0]       queued_sum_q, queued_sum_d;
  logic             reject_q;
  logic [7:0]       reject_val_q;

  assign coin_val_w   = coin_value(coin_code_t'(bus.coin_code));
  assign push_w       = bus.coin_valid && bus.coin_ready;
  // 9-bit sum so a ceiling near 255 cannot be defeated by wrap-around.
  assign credit_sum_w = {1'b0, credit_q} + {1'b0, coin_val_w};
  assign over_w       = credit_sum_w > {1'b0, MAX_CREDIT};
  assign enq_w        = push_w && !over_w;
  assign rej_w        = push_w && over_w;
  // Pop is taken at the edge that moves IDLE -> PRESENT.
  assign pop_w        = (state_q == IDLE) && !empty_w && bus.accept_en;

  // Ready reflects the pre-pop occupancy, so a full FIFO never takes a
  // coin even in the cycle it is being popped.
  assign bus.coin_ready   = !full_w;
  assign bus.input_money  = money_q;
  assign bus.coin_reject  = reject_q;
  assign bus.reject_value = reject_val_q;
  assign bus.credit       = credit_q;
  assign bus.fifo_count   = count_w;

  coin_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (enq_w),
    .pop_i   (pop_w),
    .wdata_i (coin_val_w),
    .rdata_o (head_w),
    .count_o (count_w),
    .full_o  (full_w),
    .empty_o (empty_w)
  );

  // queued_sum tracks value sitting in the FIFO; a session clear drops the
  // delivered part of credit and keeps what is still queued.
  always_comb begin
    queued_sum_d = queued_sum_q;
    credit_d     = credit_q;
    if (enq_w) begin
      queued_sum_d = queued_sum_d + coin_val_w;
      credit_d     = credit_d + coin_val_w;
    end
    if (pop_w) begin
      queued_sum_d = queued_sum_d - head_w;
    end
    if (bus.session_clear) begin
      credit_d = queued_sum_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_q     <= '0;
      queued_sum_q <= '0;
      reject_q     <= 1'b0;
      reject_val_q <= '0;
    end else begin
      credit_q     <= credit_d;
      queued_sum_q <= queued_sum_d;
      reject_q     <= rej_w;
      if (rej_w) begin
        reject_val_q <= coin_val_w;
      end
    end
  end

  // Delivery FSM with registered money output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      money_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          money_q <= '0;
          if (pop_w) begin
            state_q <= PRESENT;
            money_q <= head_w;
          end
        end
        PRESENT: begin
          state_q <= GAP;
          money_q <= '0;
        end
        GAP: begin
          state_q <= IDLE;
          money_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          money_q <= '0;
        end
      endcase
    end
  end

`ifdef COIN_AUDIT_EN
  for (genvar g = 0; g < 4; g++) begin : g_audit
    logic [15:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (enq_w && (bus.coin_code == 2'(g)) && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign bus.audit_counts[16*g +: 16] = cnt_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_acceptor
//  Description : Self-checking bench for coin_acceptor. Expected money pulses
//                are queued when a coin is accepted and popped when the DUT
//                pulses input_money. Credit/reject/queued value are modelled
//                independently of the DUT.
//  Macro       : COIN_AUDIT_EN (enables audit counter scenario)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_coin_acceptor;
  import coin_pkg::*;

  localparam int         FIFO_DEPTH = 4;
  localparam logic [7:0] MAX_CREDIT = 8'd200;

  logic clk;
  logic reset;

  coin_acceptor_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  coin_acceptor #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_CREDIT (MAX_CREDIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         model_credit = 0;
  int         model_queued = 0;
  bit         tight = 1'b0;
  int         burst_n = 0;
  int         zeros = 99;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int val_of(input logic [1:0] code);
    case (code)
      2'b00:   return 1;
      2'b01:   return 5;
      2'b10:   return 10;
      default: return 50;
    endcase
  endfunction

  // Output monitor: scoreboard pop plus pulse spacing.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        zeros = 99;
      end else if (bus.input_money != 8'd0) begin
        check("gap_min", {63'd0, zeros >= 2}, 64'd1);
        if (tight && burst_n > 0) check("gap_exact", zeros, 2);
        burst_n++;
        if (exp_q.size() == 0) begin
          check("unexpected_money", bus.input_money, 0);
        end else begin
          e = exp_q.pop_front();
          check("money", bus.input_money, e);
          model_queued -= int'(e);
        end
        zeros = 0;
      end else if (zeros < 99) begin
        zeros++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    model_credit = 0;
    model_queued = 0;
    tick();
    reset = 1'b0;
  endtask

  // Called 1 time unit after a posedge; returns 1 time unit after the next.
  task automatic push_coin(input logic [1:0] code, input bit exp_taken);
    int v;
    bit over;
    v    = val_of(code);
    over = (model_credit + v) > int'(MAX_CREDIT);
    bus.coin_valid = 1'b1;
    bus.coin_code  = code;
    #1;
    check("coin_ready", bus.coin_ready, exp_taken);
    tick();
    bus.coin_valid = 1'b0;
    if (exp_taken && over) begin
      check("coin_reject", bus.coin_reject, 1);
      check("reject_value", bus.reject_value, v);
    end else begin
      check("no_reject", bus.coin_reject, 0);
      if (exp_taken) begin
        exp_q.push_back(8'(v));
        model_credit += v;
        model_queued += v;
      end
    end
    check("credit", bus.credit, model_credit);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_session();
    bus.session_clear = 1'b1;
    tick();
    bus.session_clear = 1'b0;
    model_credit = model_queued;
    check("credit_clear", bus.credit, model_credit);
  endtask

  initial begin
    reset = 1'b1;
    bus.coin_valid    = 1'b0;
    bus.coin_code     = 2'b00;
    bus.accept_en     = 1'b0;
    bus.session_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_money", bus.input_money, 0);
    check("rst_reject", bus.coin_reject, 0);
    check("rst_reject_value", bus.reject_value, 0);
    check("rst_credit", bus.credit, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_ready", bus.coin_ready, 1);

    // 1: single code-10 coin, one-cycle latency, one-cycle pulse
    bus.accept_en = 1'b1;
    push_coin(2'b10, 1'b1);
    tick();
    check("t1_pulse", bus.input_money, 10);
    tick();
    check("t1_after", bus.input_money, 0);
    drain();
    check("t1_credit", bus.credit, 10);

    // 2: queue while disabled, fifth coin refused, then tight replay
    bus.accept_en = 1'b0;
    for (int i = 0; i < 4; i++) push_coin(2'(i), 1'b1);
    push_coin(2'b00, 1'b0);
    check("t2_count", bus.fifo_count, 4);
    check("t2_money_idle", bus.input_money, 0);
    tight   = 1'b1;
    burst_n = 0;
    bus.accept_en = 1'b1;
    drain();
    tight = 1'b0;
    check("t2_burst", burst_n, 4);
    check("t2_count_empty", bus.fifo_count, 0);

    // 3: credit ceiling
    do_reset();
    bus.accept_en = 1'b1;
    for (int i = 0; i < 3; i++) begin push_coin(2'b11, 1'b1); drain(); end
    for (int i = 0; i < 4; i++) begin push_coin(2'b10, 1'b1); drain(); end
    check("t3_credit190", bus.credit, 190);
    push_coin(2'b01, 1'b1);
    check("t3_credit195", bus.credit, 195);
    push_coin(2'b10, 1'b1);
    check("t3_credit_hold", bus.credit, 195);
    tick();
    check("t3_reject_one_cycle", bus.coin_reject, 0);
    check("t3_reject_value_held", bus.reject_value, 10);
    drain();
    for (int i = 0; i < 5; i++) push_coin(2'b00, 1'b1);
    check("t3_credit_max", bus.credit, 200);
    push_coin(2'b00, 1'b1);
    check("t3_reject_value_1", bus.reject_value, 1);
    drain();

    // 4: session clear keeps queued value
    do_reset();
    bus.accept_en = 1'b1;
    push_coin(2'b10, 1'b1); drain();
    push_coin(2'b10, 1'b1); drain();
    push_coin(2'b01, 1'b1); drain();
    bus.accept_en = 1'b0;
    push_coin(2'b01, 1'b1);
    push_coin(2'b10, 1'b1);
    check("t4_credit40", bus.credit, 40);
    check("t4_count", bus.fifo_count, 2);
    clear_session();
    check("t4_credit15", bus.credit, 15);
    bus.accept_en = 1'b1;
    drain();
    check("t4_credit_after", bus.credit, 15);

    // 5: reset during PRESENT
    do_reset();
    bus.accept_en = 1'b1;
    push_coin(2'b11, 1'b1);
    push_coin(2'b00, 1'b1);
    check("t5_present", bus.input_money, 50);
    check("t5_count", bus.fifo_count, 1);
    #2;
    reset = 1'b1;
    exp_q.delete();
    model_credit = 0;
    model_queued = 0;
    #1;
    check("t5_money_rst", bus.input_money, 0);
    check("t5_count_rst", bus.fifo_count, 0);
    check("t5_credit_rst", bus.credit, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) tick();
    check("t5_quiet", bus.input_money, 0);

`ifdef COIN_AUDIT_EN
    // 6: audit counters
    do_reset();
    bus.accept_en = 1'b1;
    for (int i = 0; i < 15; i++) begin push_coin(2'b10, 1'b1); drain(); end
    for (int i = 0; i < 3; i++) begin push_coin(2'b00, 1'b1); drain(); end
    push_coin(2'b11, 1'b1);
    drain();
    check("t6_cnt00", bus.audit_counts[15:0], 3);
    check("t6_cnt10", bus.audit_counts[47:32], 15);
    check("t6_cnt11", bus.audit_counts[63:48], 0);
    clear_session();
    check("t6_cnt00_clear", bus.audit_counts[15:0], 3);
    check("t6_cnt10_clear", bus.audit_counts[47:32], 15);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
